// File: rtl/id_ex_skid_pkg.sv
// Shared decode/execute definitions: widths, R-type encodings and the canonical NOP.
package id_ex_skid_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned RDATA_WIDTH_DEF = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;

  // addi x0,x0,0
  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/id_ex_skid_reg.sv
// Single-entry register with a valid bit; only the valid bit is reset.
module skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    if (clr_i)       valid_d = 1'b0;
    else if (load_i) valid_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (load_i) data_q <= data_i;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline register with a two-entry skid buffer and flush.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned             INST_WIDTH = RDATA_WIDTH_DEF,
  parameter logic [INST_WIDTH-1:0]   NOP_INST   = INST_WIDTH'(INST_NOP)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] op1_o,
  output logic [DATA_WIDTH-1:0] op2_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [1:0]            occupancy_o
);

  localparam int unsigned EW = 2 * DATA_WIDTH + INST_WIDTH;

  logic          main_v, skid_v;
  logic [EW-1:0] main_q, skid_q, in_entry, main_din;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          accept, fire;
  skid_state_e   state;

  assign in_entry = {inst_i, op2_i, op1_i};

  always_comb begin
    if (skid_v)      state = ST_FULL;
    else if (main_v) state = ST_ONE;
    else             state = ST_EMPTY;
  end

  assign in_ready_o  = ~skid_v & ~rst_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = main_v;
  assign fire        = main_v & out_ready_i;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_din  = in_entry;
    unique case (state)
      ST_EMPTY: main_load = accept;
      ST_ONE: begin
        if (fire & accept)       main_load = 1'b1;
        else if (fire)           main_clr  = 1'b1;
        else if (accept)         skid_load = 1'b1;
      end
      ST_FULL: begin
        if (fire) begin
          main_load = 1'b1;
          main_din  = skid_q;
          skid_clr  = 1'b1;
        end
      end
      default: ;
    endcase
    // Flush overrides any same-cycle accept; a same-cycle fire already completed.
    if (flush_i) begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  skid_reg #(.WIDTH(EW)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .data_i  (main_din),
    .valid_o (main_v),
    .data_o  (main_q)
  );

  skid_reg #(.WIDTH(EW)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .data_i  (in_entry),
    .valid_o (skid_v),
    .data_o  (skid_q)
  );

  assign op1_o       = main_v ? main_q[DATA_WIDTH-1:0]            : '0;
  assign op2_o       = main_v ? main_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign inst_o      = main_v ? main_q[EW-1:2*DATA_WIDTH]         : NOP_INST;
  assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Pipeline register and two-entry skid buffer between the decode stage and the R-type execute stage.
- Captures decoded operands and the instruction word, then presents them to execute with a valid/ready handshake.
- Registers the upstream ready, so decode never sees a combinational path from execute back-pressure.
- Supports a pipeline flush. When the block holds nothing, it drives a canonical NOP so execute computes nothing harmful.

Parameters:
- DATA_WIDTH, 32, operand width (matches `DATA_WIDTH`).
- INST_WIDTH, 32, instruction word width (matches `RDATA_WIDTH`).
- NOP_INST, 32'h00000013, instruction driven while empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- flush_i  in  1  discard all held and incoming entries.
- in_valid_i  in  1  decode presents an entry.
- in_ready_o  out  1  block can accept an entry this cycle.
- op1_i  in  DATA_WIDTH  operand 1 from decode.
- op2_i  in  DATA_WIDTH  operand 2 from decode.
- inst_i  in  INST_WIDTH  instruction word.
- out_valid_o  out  1  entry presented to execute.
- out_ready_i  in  1  execute consumes the entry this cycle.
- op1_o  out  DATA_WIDTH  operand 1 to execute.
- op2_o  out  DATA_WIDTH  operand 2 to execute.
- inst_o  out  INST_WIDTH  instruction to execute.
- occupancy_o  out  2  number of held entries (0..2).

Interface (already decided): one clock, clk_i. Reset rst_i is synchronous and active-high.

Behaviour:
- Definitions: accept = in_valid_i & in_ready_o. fire = out_valid_o & out_ready_i.
- Storage: a main register (drives the outputs) and a skid register, each with its own valid bit.
- State is derived from the valid bits: EMPTY (none), ONE (main only), FULL (main and skid). Skid valid never occurs without main valid.
- in_ready_o = !skid_valid & !rst_i. It depends only on registered state plus reset.
- out_valid_o = main_valid.
- While !main_valid: op1_o = 0, op2_o = 0, inst_o = NOP_INST.
- occupancy_o = main_valid + skid_valid.
- Reset: takes effect at the clock edge where rst_i=1. Afterwards the state is EMPTY, out_valid_o=0, occupancy_o=0, outputs at NOP/0, and in_ready_o=1 once rst_i deasserts. Inputs presented while rst_i=1 are never captured; in_ready_o=0 during reset.
- Flush: priority just below reset. The next state is EMPTY, including any entry accepted in the same cycle, which is discarded. A same-cycle fire is still a completed transfer.
- Transitions without reset or flush:
  - EMPTY, accept -> ONE; main <= input.
  - ONE, fire & accept -> ONE; main <= input.
  - ONE, fire & !accept -> EMPTY.
  - ONE, !fire & accept -> FULL; skid <= input.
  - ONE, neither -> hold.
  - FULL, fire -> ONE; main <= skid. No accept is possible, because in_ready_o=0.
  - FULL, !fire -> hold.
- Latency: an accepted entry appears on the outputs the following cycle. Sustained throughput is 1 entry/cycle when out_ready_i stays high.
- Stability: while out_valid_o & !out_ready_i, all outputs hold bit-exact.
- Ordering: strictly FIFO. No entry is duplicated or dropped, except by flush or reset.
- Data registers need no reset; only the valid bits reset. The output muxing to NOP/0 hides stale data.
- Execute drives its write enable unconditionally, so writeback must qualify execute's write enable with out_valid_o & out_ready_i. This block guarantees inst_o=NOP_INST whenever it is empty.

Decomposition:
- Shared defines file: add `INST_NOP` (32'h00000013) alongside the existing opcode/funct3 and width macros. NOP_INST defaults to it.
- One natural sub-module, skid_reg: a generic single-entry register with valid bit, parameterised on width, load enable and clear. Instantiate it twice (main and skid), with the state logic in id_ex_skid.

Test Plan:
- Reset: hold rst_i high 2 cycles with in_valid_i=1 -> out_valid_o=0, inst_o=32'h00000013, occupancy_o=0, in_ready_o=0. After release, in_ready_o=1.
- Streaming: out_ready_i=1; push 4 entries (op1=1..4, op2=10..40, inst=ADD 32'h002081B3) on consecutive cycles -> each appears exactly 1 cycle later, in order. occupancy_o stays 1, no bubbles.
- Back-pressure: out_ready_i=0; push A=(5,7,SUB 32'h402081B3), B, C -> A and B accepted, occupancy_o=2, in_ready_o=0, C held off and outputs stable on A. Raise out_ready_i -> A, B, C emerge in order with no loss.
- Flush while FULL: occupancy_o=2; assert flush_i with in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, inst_o=NOP. The incoming entry never appears.
- Simultaneous fire and accept in ONE: hold X, set out_ready_i=1, present Y -> next cycle outputs show Y and occupancy_o=1.
- Reset mid-operation: FULL, then assert rst_i for 1 cycle -> EMPTY. The first accepted entry after release is the first one output; no stale entries appear.
